// File: rtl/sync_fifo_pkg.sv
// Shared types and elaboration helpers for the parametrised sync FIFO.
// Status bundle, address-width helper and parameter legality check.
package sync_fifo_pkg;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
      logic overflow;
      logic underflow;
   } status_t;

   localparam status_t STATUS_RST = '{
      full:         1'b0,
      empty:        1'b1,
      almost_full:  1'b0,
      almost_empty: 1'b1,
      overflow:     1'b0,
      underflow:    1'b0
   };

   function automatic int calc_aw(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   function automatic bit params_ok(
      input int data_w,
      input int depth,
      input int af,
      input int ae,
      input int fwft
   );
      bit ok;
      ok = 1'b1;
      if (data_w < 1) ok = 1'b0;
      if (!is_pow2(depth) || depth < 4) ok = 1'b0;
      if (af < 1 || af > depth) ok = 1'b0;
      if (ae < 0 || ae > depth - 1) ok = 1'b0;
      if (af <= ae) ok = 1'b0;
      if (fwft != 0 && fwft != 1) ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Flop-array storage for the sync FIFO.
// One synchronous write port, one asynchronous read port, no reset.
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int AW     = 4
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered flags, fill level,
// sticky overflow/underflow and standard or fall-through read.
module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   parameter int FWFT      = 0,
   localparam int AW       = calc_aw(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] data_in,
   input  logic              rd_en,
   output logic [DATA_W-1:0] data_out,
   output logic              fifo_full,
   output logic              fifo_empty,
   output logic              fifo_almost_full,
   output logic              fifo_almost_empty,
   output logic [AW:0]       fill_count,
   output logic              overflow,
   output logic              underflow,
   input  logic              err_clr
);

   if (!params_ok(DATA_W, DEPTH, AF_THRESH, AE_THRESH, FWFT))
   begin : g_param_err
      $error("sync_fifo_param: illegal parameter set");
   end

   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   AF_LVL  = (AW + 1)'(AF_THRESH);
   localparam logic [AW:0]   AE_LVL  = (AW + 1)'(AE_THRESH);

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   status_t           st_q, st_d;
   logic              wr_ok, rd_ok;
   logic [DATA_W-1:0] rd_data;

   // Accept decisions only look at the registered flags.
   assign wr_ok = wr_en && !st_q.full;
   assign rd_ok = rd_en && !st_q.empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case (1'b1)
         (wr_ok && !rd_ok): count_d = count_q + CNT_ONE;
         (!wr_ok && rd_ok): count_d = count_q - CNT_ONE;
         default:           count_d = count_q;
      endcase
   end

   always_comb begin
      st_d              = st_q;
      st_d.full         = (count_d == CNT_MAX);
      st_d.empty        = (count_d == '0);
      st_d.almost_full  = (count_d >= AF_LVL);
      st_d.almost_empty = (count_d <= AE_LVL);
      if (err_clr) begin
         st_d.overflow  = 1'b0;
         st_d.underflow = 1'b0;
      end
      // A new error in the clearing cycle must not be lost.
      if (wr_en && st_q.full)  st_d.overflow  = 1'b1;
      if (rd_en && st_q.empty) st_d.underflow = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         st_q     <= STATUS_RST;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         st_q     <= st_d;
      end
   end

   sync_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_ok && !reset),
      .wr_addr (wr_ptr_q),
      .wr_data (data_in),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_data)
   );

   if (FWFT != 0) begin : g_fwft
      assign data_out = rd_data;
   end else begin : g_std
      logic [DATA_W-1:0] dout_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            dout_q <= '0;
         end else if (rd_ok) begin
            dout_q <= rd_data;
         end
      end

      assign data_out = dout_q;
   end

   assign fill_count        = count_q;
   assign fifo_full         = st_q.full;
   assign fifo_empty        = st_q.empty;
   assign fifo_almost_full  = st_q.almost_full;
   assign fifo_almost_empty = st_q.almost_empty;
   assign overflow          = st_q.overflow;
   assign underflow         = st_q.underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: standard and fall-through instances driven
// together, checked against a queue-based reference model.
module tb_sync_fifo_param;

   localparam int DW = 32;
   localparam int D  = 16;
   localparam int AF = 14;
   localparam int AE = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic          err_clr = 1'b0;
   logic [DW-1:0] data_in = '0;

   logic [DW-1:0] dout0, dout1;
   logic          full0, empty0, af0, ae0, ov0, un0;
   logic          full1, empty1, af1, ae1, ov1, un1;
   logic [4:0]    fc0, fc1;

   int n_chk = 0;
   int n_fail = 0;

   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_dout = '0;
   logic          m_ov = 1'b0;
   logic          m_un = 1'b0;

   always #5 clk = ~clk;

   sync_fifo_param #(
      .DATA_W(DW), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)
   ) dut0 (
      .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in),
      .rd_en(rd_en), .data_out(dout0), .fifo_full(full0),
      .fifo_empty(empty0), .fifo_almost_full(af0),
      .fifo_almost_empty(ae0), .fill_count(fc0), .overflow(ov0),
      .underflow(un0), .err_clr(err_clr)
   );

   sync_fifo_param #(
      .DATA_W(DW), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)
   ) dut1 (
      .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in),
      .rd_en(rd_en), .data_out(dout1), .fifo_full(full1),
      .fifo_empty(empty1), .fifo_almost_full(af1),
      .fifo_almost_empty(ae1), .fill_count(fc1), .overflow(ov1),
      .underflow(un1), .err_clr(err_clr)
   );

   // Drive one cycle, advance the reference model, then settle past the edge.
   task automatic step(input logic w, input logic [DW-1:0] d,
                       input logic r, input logic c, input logic rs);
      bit was_full, was_empty;
      wr_en = w; data_in = d; rd_en = r; err_clr = c; reset = rs;
      @(posedge clk);
      if (rs) begin
         mq.delete();
         m_ov = 1'b0;
         m_un = 1'b0;
         m_dout = '0;
      end else begin
         was_full  = (mq.size() == D);
         was_empty = (mq.size() == 0);
         if (r && !was_empty) m_dout = mq.pop_front();
         if (w && !was_full) mq.push_back(d);
         m_ov = (w && was_full) ? 1'b1 : (c ? 1'b0 : m_ov);
         m_un = (r && was_empty) ? 1'b1 : (c ? 1'b0 : m_un);
      end
      #1;
      wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; reset = 1'b0;
   endtask

   task automatic test_reset();
      step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
      n_chk++;
      if ({fc0, empty0, ae0, full0, af0, ov0, un0} !== {5'd0, 6'b110000}) begin
         n_fail++;
         $display("FAIL reset_flags0 got fc=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b want 0 1 1 0 0 0 0",
                  fc0, empty0, ae0, full0, af0, ov0, un0);
      end
      n_chk++;
      if ({fc1, empty1, ae1, full1, af1, ov1, un1} !== {5'd0, 6'b110000}) begin
         n_fail++;
         $display("FAIL reset_flags1 got fc=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b want 0 1 1 0 0 0 0",
                  fc1, empty1, ae1, full1, af1, ov1, un1);
      end
      n_chk++;
      if (dout0 !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_dout got %h want 0", dout0);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < D; i++) begin
         step(1'b1, DW'(i + 1), 1'b0, 1'b0, 1'b0);
         n_chk++;
         if (fc0 !== 5'(i + 1) || af0 !== (i + 1 >= AF) || full0 !== (i == D - 1)) begin
            n_fail++;
            $display("FAIL fill_%0d got fc=%0d af=%b f=%b want %0d %b %b",
                     i, fc0, af0, full0, i + 1, (i + 1 >= AF), (i == D - 1));
         end
      end
   endtask

   task automatic test_drain();
      for (int i = 0; i < D; i++) begin
         n_chk++;
         if (dout1 !== DW'(i + 1)) begin
            n_fail++;
            $display("FAIL fwft_head_%0d got %h want %h", i, dout1, i + 1);
         end
         step(1'b0, '0, 1'b1, 1'b0, 1'b0);
         n_chk++;
         if (dout0 !== DW'(i + 1) || ae0 !== (D - 1 - i <= AE)) begin
            n_fail++;
            $display("FAIL drain_%0d got d=%h ae=%b want %h %b",
                     i, dout0, ae0, i + 1, (D - 1 - i <= AE));
         end
      end
      n_chk++;
      if (empty0 !== 1'b1 || empty1 !== 1'b1 || fc0 !== 5'd0) begin
         n_fail++;
         $display("FAIL drain_empty got e0=%b e1=%b fc=%0d want 1 1 0", empty0, empty1, fc0);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < D; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
      n_chk++;
      if (fc0 !== 5'd16 || ov0 !== 1'b1 || ov1 !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_set got fc=%0d ov0=%b ov1=%b want 16 1 1", fc0, ov0, ov1);
      end
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      n_chk++;
      if (ov0 !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_hold got %b want 1", ov0);
      end
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      n_chk++;
      if (ov0 !== 1'b0 || ov1 !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clr got %b %b want 0 0", ov0, ov1);
      end
      step(1'b1, 32'hBEEF, 1'b0, 1'b1, 1'b0);
      n_chk++;
      if (ov0 !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_set_wins got %b want 1", ov0);
      end
      step(1'b1, 32'hCAFE, 1'b1, 1'b1, 1'b0);
      n_chk++;
      if (fc0 !== 5'd15 || ov0 !== 1'b1 || dout0 !== m_dout) begin
         n_fail++;
         $display("FAIL ovf_rd_ok got fc=%0d ov=%b d=%h want 15 1 %h", fc0, ov0, dout0, m_dout);
      end
      while (mq.size() != 0) begin
         step(1'b0, '0, 1'b1, 1'b0, 1'b0);
         n_chk++;
         if (dout0 !== m_dout) begin
            n_fail++;
            $display("FAIL ovf_drain got %h want %h", dout0, m_dout);
         end
      end
   endtask

   task automatic test_underflow();
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n_chk++;
      if (un0 !== 1'b1 || un1 !== 1'b1 || fc0 !== 5'd0 || empty0 !== 1'b1) begin
         n_fail++;
         $display("FAIL udf_set got un=%b%b fc=%0d e=%b want 11 0 1", un0, un1, fc0, empty0);
      end
      step(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
      n_chk++;
      if (fc0 !== 5'd1 || un0 !== 1'b1 || dout1 !== 32'h55 || dout0 !== 32'h0) begin
         n_fail++;
         $display("FAIL udf_wr got fc=%0d un=%b d1=%h d0=%h want 1 1 55 0", fc0, un0, dout1, dout0);
      end
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n_chk++;
      if (dout0 !== 32'h55 || empty0 !== 1'b1) begin
         n_fail++;
         $display("FAIL udf_pop got d=%h e=%b want 55 1", dout0, empty0);
      end
   endtask

   task automatic test_back_to_back();
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         step(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
         n_chk++;
         if (fc0 !== 5'd8 || dout0 !== m_dout || dout1 !== mq[0]) begin
            n_fail++;
            $display("FAIL b2b_%0d got fc=%0d d0=%h d1=%h want 8 %h %h",
                     i, fc0, dout0, dout1, m_dout, mq[0]);
         end
      end
   endtask

   task automatic test_fwft();
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'hA5, 1'b0, 1'b0, 1'b0);
      n_chk++;
      if (dout1 !== 32'hA5 || empty1 !== 1'b0) begin
         n_fail++;
         $display("FAIL fwft_first got d=%h e=%b want a5 0", dout1, empty1);
      end
      for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h77, 1'b1, 1'b0, 1'b1);
      n_chk++;
      if (fc1 !== 5'd0 || empty1 !== 1'b1 || fc0 !== 5'd0 || dout0 !== 32'h0) begin
         n_fail++;
         $display("FAIL fwft_reset got fc1=%0d e1=%b fc0=%0d d0=%h want 0 1 0 0",
                  fc1, empty1, fc0, dout0);
      end
   endtask

   task automatic test_random();
      int wp, rp;
      for (int i = 0; i < 600; i++) begin
         wp = (i < 300) ? 70 : 35;
         rp = (i < 300) ? 35 : 70;
         step($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < rp,
              $urandom_range(0, 99) < 5, $urandom_range(0, 199) == 0);
         n_chk++;
         if (fc0 !== 5'(mq.size()) || fc1 !== 5'(mq.size()) ||
             full0 !== (mq.size() == D) || empty0 !== (mq.size() == 0) ||
             af0 !== (mq.size() >= AF) || ae0 !== (mq.size() <= AE) ||
             ov0 !== m_ov || un0 !== m_un || ov1 !== m_ov || un1 !== m_un ||
             dout0 !== m_dout) begin
            n_fail++;
            $display("FAIL rand_%0d got fc=%0d f=%b e=%b af=%b ae=%b ov=%b un=%b d0=%h want fc=%0d ov=%b un=%b d0=%h",
                     i, fc0, full0, empty0, af0, ae0, ov0, un0, dout0,
                     mq.size(), m_ov, m_un, m_dout);
         end
         if (mq.size() != 0) begin
            n_chk++;
            if (dout1 !== mq[0]) begin
               n_fail++;
               $display("FAIL rand_head_%0d got %h want %h", i, dout1, mq[0]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_overflow();
      test_underflow();
      test_back_to_back();
      test_fwft();
      test_random();
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
